// File: rtl/sync_fifo_n.sv
// sync_fifo_n: single-clock parametrised-depth FIFO with occupancy count, threshold flags and error pulses
// Ports: clk, rst_n (sync active-low); write side wr/wr_data/full/almost_full;
// read side rd/rd_data (registered)/empty_n/almost_empty; count = occupancy 0..DEPTH;
// overflow/underflow pulse for one cycle after a dropped write / ignored read.
module sync_fifo_n #(
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BUS_WIDTH-1:0]  wr_data,
  input  logic                  wr,
  output logic                  full,
  output logic                  almost_full,
  output logic [BUS_WIDTH-1:0]  rd_data,
  input  logic                  rd,
  output logic                  empty_n,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE    = (ADDR_WIDTH+1)'(AE_THRESH);
  logic [BUS_WIDTH-1:0]  mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  wa, ra;
  // a write into a full FIFO is allowed when a read frees a slot in the same cycle
  always_comb begin
    ra        = rd & empty_n;
    wa        = wr & (~full | ra);
    count_nxt = count + (ADDR_WIDTH+1)'(wa) - (ADDR_WIDTH+1)'(ra);
  end
  always_ff @(posedge clk)
    if (rst_n && wa) mem[wptr] <= wr_data;
  // flags are registered from count_nxt so they track post-edge occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty_n      <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rd_data      <= '0;
    end else begin
      if (wa) wptr <= wptr + ADDR_WIDTH'(1);
      if (ra) begin
        rptr    <= rptr + ADDR_WIDTH'(1);
        rd_data <= mem[rptr];
      end
      count        <= count_nxt;
      full         <= count_nxt == DEPTH;
      empty_n      <= count_nxt != '0;
      almost_full  <= count_nxt >= AF;
      almost_empty <= count_nxt <= AE;
      overflow     <= wr & full & ~rd;
      underflow    <= rd & ~empty_n;
    end
  end
endmodule

// File: tb/tb_sync_fifo_n.sv
// tb_sync_fifo_n: self-checking bench for sync_fifo_n (DEPTH=8, AF=6, AE=1)
module tb_sync_fifo_n;
  logic        clk = 1'b0;
  logic        rst_n, wr, rd;
  logic [15:0] wr_data, rd_data;
  logic        full, almost_full, empty_n, almost_empty, overflow, underflow;
  logic [3:0]  count;
  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] mq[$];
  logic [15:0] sb[$];
  logic [15:0] last;
  typedef struct {
    logic        wr, rd;
    logic [15:0] wd;
    logic [3:0]  cnt;
    logic        full, af, ae, en, ov, un;
  } vec_t;
  vec_t tv[17];

  sync_fifo_n dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr(wr), .full(full),
    .almost_full(almost_full), .rd_data(rd_data), .rd(rd), .empty_n(empty_n),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; wr_data = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mq.delete(); sb.delete(); last = '0;
    chk("rst_count", count, 0);
    chk("rst_empty_n", empty_n, 0);
    chk("rst_full", full, 0);
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
  endtask

  // drive one cycle; an independent queue model predicts status, the scoreboard predicts rd_data
  task automatic step(input logic w, input logic r, input logic [15:0] d);
    int sz;
    logic ra, wa, ov, un;
    sz = mq.size();
    ra = r && sz != 0;
    wa = w && (sz < 8 || ra);
    ov = w && sz == 8 && !r;
    un = r && sz == 0;
    wr = w; rd = r; wr_data = d;
    if (ra) sb.push_back(mq.pop_front());
    if (wa) mq.push_back(d);
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
    if (ra) last = sb.pop_front();
    chk("rd_data", rd_data, last);
    chk("count", count, mq.size());
    chk("full", full, mq.size() == 8);
    chk("empty_n", empty_n, mq.size() != 0);
    chk("almost_full", almost_full, mq.size() >= 6);
    chk("almost_empty", almost_empty, mq.size() <= 1);
    chk("overflow", overflow, ov);
    chk("underflow", underflow, un);
  endtask

  initial begin
    //          wr rd wd        cnt full af ae en ov un
    tv[0]  = '{1, 0, 16'h0001, 1, 0, 0, 1, 1, 0, 0};
    tv[1]  = '{1, 0, 16'h0002, 2, 0, 0, 0, 1, 0, 0};
    tv[2]  = '{1, 0, 16'h0003, 3, 0, 0, 0, 1, 0, 0};
    tv[3]  = '{1, 0, 16'h0004, 4, 0, 0, 0, 1, 0, 0};
    tv[4]  = '{1, 0, 16'h0005, 5, 0, 0, 0, 1, 0, 0};
    tv[5]  = '{1, 0, 16'h0006, 6, 0, 1, 0, 1, 0, 0};
    tv[6]  = '{1, 0, 16'h0007, 7, 0, 1, 0, 1, 0, 0};
    tv[7]  = '{1, 0, 16'h0008, 8, 1, 1, 0, 1, 0, 0};
    tv[8]  = '{0, 1, 16'h0000, 7, 0, 1, 0, 1, 0, 0};
    tv[9]  = '{0, 1, 16'h0000, 6, 0, 1, 0, 1, 0, 0};
    tv[10] = '{0, 1, 16'h0000, 5, 0, 0, 0, 1, 0, 0};
    tv[11] = '{0, 1, 16'h0000, 4, 0, 0, 0, 1, 0, 0};
    tv[12] = '{0, 1, 16'h0000, 3, 0, 0, 0, 1, 0, 0};
    tv[13] = '{0, 1, 16'h0000, 2, 0, 0, 0, 1, 0, 0};
    tv[14] = '{0, 1, 16'h0000, 1, 0, 0, 1, 1, 0, 0};
    tv[15] = '{0, 1, 16'h0000, 0, 0, 0, 1, 0, 0, 0};
    tv[16] = '{0, 1, 16'h0000, 0, 0, 0, 1, 0, 0, 1};
    do_reset();
    step(0, 0, 16'h0);
    for (int i = 0; i < 3; i++) step(1, 0, 16'h00A0 + 16'(i));
    do_reset();
    // fill and drain, rd_data 1..8 checked by the scoreboard
    for (int i = 0; i < 17; i++) begin
      step(tv[i].wr, tv[i].rd, tv[i].wd);
      chk("tv_count", count, tv[i].cnt);
      chk("tv_full", full, tv[i].full);
      chk("tv_almost_full", almost_full, tv[i].af);
      chk("tv_almost_empty", almost_empty, tv[i].ae);
      chk("tv_empty_n", empty_n, tv[i].en);
      chk("tv_overflow", overflow, tv[i].ov);
      chk("tv_underflow", underflow, tv[i].un);
    end
    chk("tv_last_word", rd_data, 16'h0008);
    // overflow while full: 0xDEAD must be dropped
    for (int i = 1; i <= 8; i++) step(1, 0, 16'(i));
    step(1, 0, 16'hDEAD);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 8);
    step(0, 0, 16'h0);
    chk("ovf_pulse_end", overflow, 0);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 16'h0);
      chk("ovf_drain", rd_data, 16'(i));
    end
    // simultaneous read and write while full
    for (int i = 1; i <= 8; i++) step(1, 0, 16'(i));
    step(1, 1, 16'hBEEF);
    chk("rw_full_rd_data", rd_data, 16'h0001);
    chk("rw_full_count", count, 8);
    chk("rw_full_full", full, 1);
    for (int i = 0; i < 8; i++) step(0, 1, 16'h0);
    chk("rw_full_last", rd_data, 16'hBEEF);
    chk("rw_full_empty", empty_n, 0);
    // simultaneous read and write while empty
    step(1, 1, 16'h1234);
    chk("rw_empty_underflow", underflow, 1);
    chk("rw_empty_rd_data", rd_data, 16'hBEEF);
    chk("rw_empty_count", count, 1);
    step(0, 1, 16'h0);
    chk("rw_empty_next", rd_data, 16'h1234);
    // pointer wrap with steady occupancy of 3
    for (int i = 0; i < 3; i++) step(1, 0, 16'h0100 + 16'(i));
    for (int i = 3; i < 23; i++) begin
      step(1, 1, 16'h0100 + 16'(i));
      chk("wrap_count", count, 3);
      chk("wrap_order", rd_data, 16'h0100 + 16'(i - 3));
    end
    for (int i = 0; i < 3; i++) step(0, 1, 16'h0);
    chk("wrap_tail", rd_data, 16'h0116);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_fifo_n.md
Name: sync_fifo_n

Overview:
- Single-clock, parametrised-depth FIFO. It is the successor to the one-word clock-crossing FIFO.
- Used inside the SDRAM controller clock domain to buffer host read/write command and data words between the host interface and the controller FSM.
- Adds the following over the one-word FIFO:
  - configurable depth,
  - occupancy count,
  - almost-full and almost-empty thresholds,
  - overflow and underflow error pulses.
- Keeps the existing full / empty_n signal polarity.

Parameters:
- BUS_WIDTH, 16, data word width in bits.
- ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 8 words).
- AF_THRESH, 6, almost_full asserts when occupancy >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 1, almost_empty asserts when occupancy <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
- wr_data  input  BUS_WIDTH  write data, captured when a write is accepted.
- wr  input  1  write request, one word per cycle.
- full  output  1  high means the write side must not write.
- almost_full  output  1  occupancy >= AF_THRESH.
- rd_data  output  BUS_WIDTH  registered read data.
- rd  input  1  read request, one word per cycle.
- empty_n  output  1  high means the read side can read.
- almost_empty  output  1  occupancy <= AE_THRESH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: a write was dropped.
- underflow  output  1  one-cycle pulse: a read was ignored.

Behaviour:
- Reset (rst_n low at posedge clk):
  - write and read pointers = 0, count = 0;
  - full = 0, empty_n = 0, almost_full = 0, almost_empty = 1;
  - overflow = 0, underflow = 0, rd_data = 0.
  - Reset mid-operation discards all stored words. The storage array is not cleared.
- Storage: DEPTH x BUS_WIDTH register array.
  - ADDR_WIDTH-bit pointers wrap naturally from DEPTH-1 to 0.
  - Occupancy is tracked by the explicit count register, not by pointer comparison.
- Write accepted (wa) = wr & (~full | rd_accepted).
  - A write while full is accepted only if a read is accepted in the same cycle.
  - On wa: mem[wptr] <= wr_data, then wptr advances.
- Read accepted (ra) = rd & empty_n.
  - On ra: rd_data <= mem[rptr], then rptr advances.
  - rd_data is valid the cycle after the read edge.
  - rd_data holds its value when no read is accepted.
  - Standard mode only: no first-word fall-through.
- Simultaneous wa and ra:
  - count unchanged.
  - When count = DEPTH, the read returns the oldest word. The new word goes into the slot just freed (wptr == rptr).
  - When count = 0, ra is 0 because empty_n = 0. The write is accepted and the read is ignored with underflow.
- count_nxt = count + wa - ra.
- All status flags are registered from count_nxt, so they reflect post-edge occupancy with zero added lag:
  - full = (count_nxt == DEPTH);
  - empty_n = (count_nxt != 0);
  - almost_full = (count_nxt >= AF_THRESH);
  - almost_empty = (count_nxt <= AE_THRESH).
- Error pulses:
  - overflow <= wr & full & ~rd, i.e. a write is dropped. Data and pointers are unchanged.
  - underflow <= rd & ~empty_n. Pointers and rd_data are unchanged.
  - Each pulse is high for exactly the cycle after the offending request.
- Latency: a word written at edge N can be read at edge N+1, because empty_n is high after edge N. It appears on rd_data after edge N+1 or later.
- Back-to-back: with both sides requesting, throughput is 1 word per cycle in each direction.

Test Plan (DEPTH=8, AF_THRESH=6, AE_THRESH=1):
- Reset, then idle -> count=0, empty_n=0, full=0, almost_empty=1, almost_full=0, rd_data=0. Assert rst_n low again after 3 writes -> same values on the next cycle.
- Write 0x0001..0x0008 on 8 consecutive cycles -> count steps 1..8:
  - almost_empty drops after the 2nd write;
  - almost_full rises after the 6th;
  - full rises after the 8th.
  Then read 8 -> rd_data 0x0001..0x0008 in order, one cycle after each rd; empty_n=0 after the 8th read.
- FIFO full, wr=1 with wr_data=0xDEAD and rd=0 -> overflow pulses 1 cycle, count stays 8. Draining returns 0x0001..0x0008 with no 0xDEAD.
- FIFO full, wr=1 with wr_data=0xBEEF and rd=1 in the same cycle -> rd_data=0x0001, count stays 8, full stays 1. 0xBEEF is read out last.
- FIFO empty, rd=1 with wr=1 and wr_data=0x1234 -> underflow pulses, rd_data unchanged, count=1. The next rd returns 0x1234.
- Pointer wrap: 20 cycles of continuous write+read after preloading 3 words -> count stays 3 and the output sequence is strictly in order across the wrap.
